// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : timer_bank
// Description : Bank of independent down-counting timers with one-shot or
//               auto-reload modes, freeze, cancel and near-expiry flicker.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_bank #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned FLICK_LEN = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         t_start,
    input  logic [NUM_CH*LEN_W-1:0]   t_length,
    input  logic [NUM_CH-1:0]         t_freeze,
    input  logic [NUM_CH-1:0]         t_periodic,
    input  logic [NUM_CH-1:0]         t_cancel,
    output logic [NUM_CH-1:0]         t_busy,
    output logic [NUM_CH-1:0]         t_flicker,
    output logic [NUM_CH-1:0]         t_done,
    output logic [NUM_CH*LEN_W-1:0]   t_remaining
);

    localparam logic [1:0]       c_ST_IDLE   = 2'd0;
    localparam logic [1:0]       c_ST_RUN    = 2'd1;
    localparam logic [1:0]       c_ST_FROZEN = 2'd2;
    localparam logic [LEN_W-1:0] c_ONE       = LEN_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]       r_state_q, w_state_d;
        logic [LEN_W-1:0] r_count_q, w_count_d;
        logic [LEN_W-1:0] r_len_q,   w_len_d;
        logic             r_per_q,   w_per_d;
        logic             r_done_q,  w_done_d;
        logic [LEN_W-1:0] w_len_in;
        logic             w_busy;
        logic             w_flicker;

        assign w_len_in = t_length[i*LEN_W +: LEN_W];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state_q <= c_ST_IDLE;
                r_count_q <= '0;
                r_len_q   <= '0;
                r_per_q   <= 1'b0;
                r_done_q  <= 1'b0;
            end else begin
                r_state_q <= w_state_d;
                r_count_q <= w_count_d;
                r_len_q   <= w_len_d;
                r_per_q   <= w_per_d;
                r_done_q  <= w_done_d;
            end
        end

        // Priority: cancel beats start, start beats freeze/count.
        always_comb begin
            w_state_d = r_state_q;
            w_count_d = r_count_q;
            w_len_d   = r_len_q;
            w_per_d   = r_per_q;
            w_done_d  = 1'b0;
            if (t_cancel[i]) begin
                w_state_d = c_ST_IDLE;
                w_count_d = '0;
            end else if (t_start[i]) begin
                w_len_d = w_len_in;
                w_per_d = t_periodic[i];
                if (w_len_in == '0) begin
                    w_state_d = c_ST_IDLE;
                    w_count_d = '0;
                    w_done_d  = 1'b1;
                end else begin
                    w_count_d = w_len_in;
                    w_state_d = t_freeze[i] ? c_ST_FROZEN : c_ST_RUN;
                end
            end else begin
                case (r_state_q)
                    c_ST_IDLE: begin
                    end
                    c_ST_RUN: begin
                        if (t_freeze[i]) begin
                            w_state_d = c_ST_FROZEN;
                        end else if (r_count_q == c_ONE) begin
                            w_done_d = 1'b1;
                            if (r_per_q) begin
                                w_count_d = r_len_q;
                            end else begin
                                w_count_d = '0;
                                w_state_d = c_ST_IDLE;
                            end
                        end else begin
                            w_count_d = r_count_q - c_ONE;
                        end
                    end
                    c_ST_FROZEN: begin
                        // Leaving FROZEN costs one edge with no decrement.
                        if (!t_freeze[i]) begin
                            w_state_d = c_ST_RUN;
                        end
                    end
                    default: begin
                        w_state_d = c_ST_IDLE;
                        w_count_d = '0;
                    end
                endcase
            end
        end

        always_comb begin
            w_busy    = (r_state_q == c_ST_RUN) || (r_state_q == c_ST_FROZEN);
            w_flicker = w_busy && (32'(r_count_q) <= 32'(FLICK_LEN)) && r_count_q[0];
        end

        assign t_busy[i]                     = w_busy;
        assign t_flicker[i]                  = w_flicker;
        assign t_done[i]                     = r_done_q;
        assign t_remaining[i*LEN_W +: LEN_W] = r_count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_bank
// Description : Self-checking bench for timer_bank using a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_bank;
    localparam int NUM_CH    = 4;
    localparam int LEN_W     = 8;
    localparam int FLICK_LEN = 3;
    localparam int ALL_W     = 3*NUM_CH + NUM_CH*LEN_W;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       t_start, t_freeze, t_periodic, t_cancel;
    logic [NUM_CH*LEN_W-1:0] t_length;
    logic [NUM_CH-1:0]       t_busy, t_flicker, t_done;
    logic [NUM_CH*LEN_W-1:0] t_remaining;

    int errors = 0;
    int checks = 0;

    bit m_busy [NUM_CH];
    bit m_frz  [NUM_CH];
    bit m_per  [NUM_CH];
    bit m_done [NUM_CH];
    int m_rem  [NUM_CH];
    int m_len  [NUM_CH];

    timer_bank #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .FLICK_LEN(FLICK_LEN)) dut (
        .clk(clk), .reset(reset), .t_start(t_start), .t_length(t_length),
        .t_freeze(t_freeze), .t_periodic(t_periodic), .t_cancel(t_cancel),
        .t_busy(t_busy), .t_flicker(t_flicker), .t_done(t_done),
        .t_remaining(t_remaining)
    );

    always #5 clk = ~clk;

    // Reference behaviour: one edge of every channel from the sampled inputs.
    task automatic model_step();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int len_in;
            len_in = int'(t_length[ch*LEN_W +: LEN_W]);
            m_done[ch] = 1'b0;
            if (reset) begin
                m_busy[ch] = 0; m_frz[ch] = 0; m_per[ch] = 0; m_rem[ch] = 0; m_len[ch] = 0;
            end else if (t_cancel[ch]) begin
                m_busy[ch] = 0; m_frz[ch] = 0; m_rem[ch] = 0;
            end else if (t_start[ch]) begin
                if (len_in == 0) begin
                    m_busy[ch] = 0; m_frz[ch] = 0; m_rem[ch] = 0; m_done[ch] = 1;
                end else begin
                    m_rem[ch] = len_in; m_len[ch] = len_in; m_per[ch] = t_periodic[ch];
                    m_busy[ch] = 1; m_frz[ch] = t_freeze[ch];
                end
            end else if (m_busy[ch]) begin
                if (m_frz[ch]) begin
                    if (!t_freeze[ch]) m_frz[ch] = 0;
                end else if (t_freeze[ch]) begin
                    m_frz[ch] = 1;
                end else begin
                    m_rem[ch] = m_rem[ch] - 1;
                    if (m_rem[ch] == 0) begin
                        m_done[ch] = 1;
                        if (m_per[ch]) m_rem[ch] = m_len[ch];
                        else m_busy[ch] = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [ALL_W-1:0] exp_all();
        logic [NUM_CH-1:0]       b, d, f;
        logic [NUM_CH*LEN_W-1:0] r;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            b[ch] = m_busy[ch];
            d[ch] = m_done[ch];
            f[ch] = m_busy[ch] && (m_rem[ch] <= FLICK_LEN) && (m_rem[ch] % 2 == 1);
            r[ch*LEN_W +: LEN_W] = LEN_W'(m_rem[ch]);
        end
        return {b, d, f, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_all();
        reset = 0; t_start = '0; t_freeze = '0; t_periodic = '0; t_length = '0;
        t_cancel = '1;
        tick();
        t_cancel = '0;
    endtask

    task automatic test_reset();
        reset = 1; t_start = '1; t_freeze = '0; t_periodic = '0; t_cancel = '0;
        t_length = {NUM_CH{8'd5}};
        tick(); tick();
        checks++;
        if ({t_busy, t_done, t_flicker, t_remaining} !== '0)
            begin errors++; $display("FAIL reset_outputs: got %h expected 0", {t_busy, t_done, t_flicker, t_remaining}); end
        reset = 0; t_start = '0;
    endtask

    task automatic test_oneshot();
        int busy_n = 0, done_n = 0, done_at = -1;
        clear_all();
        t_start[0] = 1; t_length[7:0] = 8'd10;
        tick();
        t_start = '0;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) tick();
            checks++;
            if ({t_busy, t_done, t_flicker, t_remaining} !== exp_all())
                begin errors++; $display("FAIL oneshot_model i=%0d: got %h expected %h", i, {t_busy, t_done, t_flicker, t_remaining}, exp_all()); end
            if (t_busy[0]) busy_n++;
            if (t_done[0]) begin done_n++; done_at = i; end
            if (i >= 7 && i <= 9) begin
                checks++;
                if (t_flicker[0] !== ((i == 8) ? 1'b0 : 1'b1))
                    begin errors++; $display("FAIL oneshot_flicker i=%0d: got %b expected %b", i, t_flicker[0], (i != 8)); end
            end
        end
        checks++;
        if (busy_n != 10) begin errors++; $display("FAIL oneshot_busy_cycles: got %0d expected 10", busy_n); end
        checks++;
        if (done_n != 1 || done_at != 10)
            begin errors++; $display("FAIL oneshot_done: got %0d pulses at %0d expected 1 at 10", done_n, done_at); end
    endtask

    task automatic test_freeze();
        int done_n = 0, done_at = -1;
        clear_all();
        t_start[0] = 1; t_length[7:0] = 8'd10;
        tick();
        t_start = '0;
        for (int i = 0; i <= 15; i++) begin
            if (i > 0) tick();
            checks++;
            if ({t_busy, t_done, t_flicker, t_remaining} !== exp_all())
                begin errors++; $display("FAIL freeze_model i=%0d: got %h expected %h", i, {t_busy, t_done, t_flicker, t_remaining}, exp_all()); end
            if (i >= 5 && i <= 7) begin
                checks++;
                if (t_remaining[7:0] !== 8'd6 || t_flicker[0] !== 1'b0)
                    begin errors++; $display("FAIL freeze_hold i=%0d: got rem %0d flick %b expected rem 6 flick 0", i, t_remaining[7:0], t_flicker[0]); end
            end
            if (t_done[0]) begin done_n++; done_at = i; end
            if (i == 4) t_freeze[0] = 1;
            if (i == 6) t_freeze[0] = 0;
        end
        checks++;
        if (done_n != 1 || done_at != 13)
            begin errors++; $display("FAIL freeze_done: got %0d pulses at %0d expected 1 at 13", done_n, done_at); end
    endtask

    task automatic test_periodic_cancel();
        int done_n = 0, bad_pos = 0;
        clear_all();
        t_start[1] = 1; t_periodic[1] = 1; t_length[15:8] = 8'd4;
        tick();
        t_start = '0; t_periodic = '0;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) tick();
            checks++;
            if ({t_busy, t_done, t_flicker, t_remaining} !== exp_all())
                begin errors++; $display("FAIL periodic_model i=%0d: got %h expected %h", i, {t_busy, t_done, t_flicker, t_remaining}, exp_all()); end
            if (t_done[1]) begin done_n++; if (i % 4 != 0 || i > 12) bad_pos++; end
            if (i == 14) begin
                checks++;
                if (t_busy[1] !== 1'b0) begin errors++; $display("FAIL periodic_cancel_busy: got %b expected 0", t_busy[1]); end
            end
            if (i == 13) t_cancel[1] = 1;
            if (i == 14) t_cancel[1] = 0;
        end
        checks++;
        if (done_n != 3 || bad_pos != 0)
            begin errors++; $display("FAIL periodic_pulses: got %0d pulses (%0d misplaced) expected 3 (0)", done_n, bad_pos); end
    endtask

    task automatic test_restart();
        int done_n = 0, done_at = -1;
        clear_all();
        t_start[2] = 1; t_length[23:16] = 8'd20;
        tick();
        t_start = '0;
        for (int i = 0; i <= 26; i++) begin
            if (i > 0) tick();
            checks++;
            if ({t_busy, t_done, t_flicker, t_remaining} !== exp_all())
                begin errors++; $display("FAIL restart_model i=%0d: got %h expected %h", i, {t_busy, t_done, t_flicker, t_remaining}, exp_all()); end
            if (t_done[2]) begin done_n++; done_at = i; end
            if (i == 15) begin
                checks++;
                if (t_remaining[23:16] !== 8'd5) begin errors++; $display("FAIL restart_rem: got %0d expected 5", t_remaining[23:16]); end
                t_start[2] = 1; t_length[23:16] = 8'd8;
            end
            if (i == 16) t_start[2] = 0;
        end
        checks++;
        if (done_n != 1 || done_at != 24)
            begin errors++; $display("FAIL restart_done: got %0d pulses at %0d expected 1 at 24", done_n, done_at); end
        t_start[2] = 1; t_cancel[2] = 1; t_length[23:16] = 8'd9;
        tick();
        t_start = '0; t_cancel = '0;
        checks++;
        if (t_busy[2] !== 1'b0 || t_remaining[23:16] !== 8'd0 || t_done[2] !== 1'b0)
            begin errors++; $display("FAIL start_cancel: got busy %b rem %0d done %b expected 0 0 0", t_busy[2], t_remaining[23:16], t_done[2]); end
    endtask

    task automatic test_zero_and_concurrent();
        int done_at [NUM_CH];
        int lens [NUM_CH] = '{5, 7, 3, 9};
        clear_all();
        t_start[3] = 1; t_length[31:24] = 8'd0;
        tick();
        t_start = '0;
        checks++;
        if (t_done[3] !== 1'b1 || t_busy[3] !== 1'b0)
            begin errors++; $display("FAIL zero_len_pulse: got done %b busy %b expected 1 0", t_done[3], t_busy[3]); end
        tick();
        checks++;
        if (t_done[3] !== 1'b0 || t_busy[3] !== 1'b0)
            begin errors++; $display("FAIL zero_len_after: got done %b busy %b expected 0 0", t_done[3], t_busy[3]); end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            t_length[ch*LEN_W +: LEN_W] = LEN_W'(lens[ch]);
            done_at[ch] = -1;
        end
        t_start = '1;
        tick();
        t_start = '0;
        for (int i = 0; i <= 11; i++) begin
            if (i > 0) tick();
            checks++;
            if ({t_busy, t_done, t_flicker, t_remaining} !== exp_all())
                begin errors++; $display("FAIL concurrent_model i=%0d: got %h expected %h", i, {t_busy, t_done, t_flicker, t_remaining}, exp_all()); end
            for (int ch = 0; ch < NUM_CH; ch++) if (t_done[ch]) done_at[ch] = i;
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++;
            if (done_at[ch] != lens[ch])
                begin errors++; $display("FAIL concurrent_done ch%0d: got %0d expected %0d", ch, done_at[ch], lens[ch]); end
        end
    endtask

    task automatic test_reset_midrun();
        int stray = 0;
        clear_all();
        t_start[0] = 1; t_length[7:0] = 8'd10;
        tick();
        t_start = '0;
        for (int i = 1; i <= 3; i++) tick();
        checks++;
        if (t_remaining[7:0] !== 8'd7) begin errors++; $display("FAIL midrun_rem: got %0d expected 7", t_remaining[7:0]); end
        reset = 1; t_start[1] = 1; t_length[15:8] = 8'd5;
        tick();
        reset = 0; t_start = '0;
        checks++;
        if ({t_busy, t_done, t_flicker, t_remaining} !== '0)
            begin errors++; $display("FAIL midrun_reset: got %h expected 0", {t_busy, t_done, t_flicker, t_remaining}); end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (t_done !== '0 || t_busy !== '0) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL midrun_stray: got %0d active cycles expected 0", stray); end
    endtask

    task automatic test_random();
        clear_all();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                t_start[ch]    = ($urandom_range(0, 7) == 0);
                t_cancel[ch]   = ($urandom_range(0, 39) == 0);
                t_freeze[ch]   = ($urandom_range(0, 4) == 0);
                t_periodic[ch] = 1'($urandom_range(0, 1));
                t_length[ch*LEN_W +: LEN_W] = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
            end
            tick();
            checks++;
            if ({t_busy, t_done, t_flicker, t_remaining} !== exp_all())
                begin errors++; $display("FAIL random_model c=%0d: got %h expected %h", c, {t_busy, t_done, t_flicker, t_remaining}, exp_all()); end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_freeze();
        test_periodic_cancel();
        test_restart();
        test_zero_and_concurrent();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..16).
REQ-002 SHALL have parameter LEN_W, default 8, width of each channel's length and count.
REQ-003 SHALL have parameter FLICK_LEN, default 3, remaining-count threshold for flicker (0 disables flicker).
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port t_start  in  NUM_CH  per-channel start/restart request.
REQ-007 SHALL have port t_length  in  NUM_CH*LEN_W  channel i length at bits [i*LEN_W +: LEN_W].
REQ-008 SHALL have port t_freeze  in  NUM_CH  per-channel count hold.
REQ-009 SHALL have port t_periodic  in  NUM_CH  mode select, sampled with t_start: 1 = auto-reload, 0 = one-shot.
REQ-010 SHALL have port t_cancel  in  NUM_CH  per-channel abort.
REQ-011 SHALL have port t_busy  out  NUM_CH  channel in RUN or FROZEN.
REQ-012 SHALL have port t_flicker  out  NUM_CH  near-expiry blink indicator.
REQ-013 SHALL have port t_done  out  NUM_CH  one-cycle expiry pulse.
REQ-014 SHALL have port t_remaining  out  NUM_CH*LEN_W  per-channel current count, same packing as t_length.

Function
REQ-015 SHALL implement per channel an FSM with states IDLE, RUN, FROZEN; channels fully independent.
REQ-016 SHALL, in any state, apply priority per edge: reset > t_cancel > t_start > freeze/count.
REQ-017 SHALL, on t_cancel, go IDLE, clear count to 0, and not pulse t_done.
REQ-018 SHALL, on t_start with length L>=1, load count=L, latch L and t_periodic, enter FROZEN if t_freeze is high that cycle, otherwise RUN; restart from RUN/FROZEN behaves identically with no t_done pulse.
REQ-019 SHALL, on t_start with L=0, stay/go IDLE with count 0 and pulse t_done in the next cycle.
REQ-020 SHALL, in RUN with t_freeze low, decrement count by 1 per edge; with t_freeze high, hold count and enter FROZEN.
REQ-021 SHALL, in FROZEN, hold count; return to RUN on the first edge with t_freeze low (no decrement on that edge).
REQ-022 SHALL, on the decrement 1->0, register t_done high for exactly one cycle: start sampled at edge k with no freeze gives t_done high between edges k+L and k+L+1.
REQ-023 SHALL, on expiry in one-shot mode, go IDLE with count 0; in periodic mode, reload the latched L and stay RUN in the same edge (period exactly L cycles).
REQ-024 SHALL ignore t_length and t_periodic changes except on edges where t_start is sampled.
REQ-025 SHALL drive t_busy combinationally from state (1 in RUN/FROZEN).
REQ-026 SHALL drive t_flicker = t_busy & (count <= FLICK_LEN) & count[0]: toggles each counting cycle, holds while frozen, 0 when FLICK_LEN=0.
REQ-027 SHALL drive t_remaining from the count register directly; no arithmetic overflow possible (count never exceeds the latched L).

Reset
REQ-028 SHALL, on an edge with reset high, force all channels IDLE, counts and latched lengths to 0, t_done 0; t_busy, t_flicker, t_remaining are therefore 0 from the following cycle.
REQ-029 SHALL, on reset mid-run, discard the pending expiry with no t_done pulse; start requests in the reset cycle are ignored.

Verification
REQ-030 SHALL pass: ch0 start L=10 at edge k -> t_busy[0]=1 for 10 cycles, t_done[0] single pulse after edge k+10, t_flicker[0]=1,0,1 at remaining 3,2,1.
REQ-031 SHALL pass: ch0 L=10, freeze 3 cycles at remaining 6 -> t_remaining holds 6, t_flicker holds, t_done delayed to edge k+13.
REQ-032 SHALL pass: ch1 periodic L=4 -> t_done[1] every 4 cycles; t_cancel mid-period -> t_busy[1]=0 next cycle, no further pulses.
REQ-033 SHALL pass: ch2 L=20, restart with L=8 at remaining 5 -> no pulse at old expiry, t_done 8 cycles after restart; t_start+t_cancel same edge -> IDLE.
REQ-034 SHALL pass: ch3 start L=0 -> t_done[3] pulse next cycle, t_busy[3] never 1; all four channels running concurrently do not interact.
REQ-035 SHALL pass: reset asserted with ch0 remaining 7 -> all outputs 0 next cycle, no t_done pulse afterwards.
